// File: rtl/mc_pkg.sv
// Shared constants and state encoding for the multicycle MIPS-subset controller.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_BRANCHNE = 4'd12
  } state_t;

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// R-type funct decode: ALU operation code plus a flag for supported functs.
module alu_decoder
  import mc_pkg::*;
#(
  parameter int FUNCT_W    = 6,
  parameter int ALU_CTRL_W = 3
) (
  input  logic [FUNCT_W-1:0]    funct,
  output logic [ALU_CTRL_W-1:0] aluControl,
  output logic                  functValid
);

  always_comb begin
    aluControl = ALU_ADD;
    functValid = 1'b1;
    case (funct)
      FN_ADD:  aluControl = ALU_ADD;
      FN_SUB:  aluControl = ALU_SUB;
      FN_AND:  aluControl = ALU_AND;
      FN_OR:   aluControl = ALU_OR;
      FN_SLT:  aluControl = ALU_SLT;
      default: functValid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle main controller; optional bne support under CTRL_BNE_EN.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int OPCODE_W   = 6,
  parameter int FUNCT_W    = 6,
  parameter int ALU_CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0]    funct,
  input  logic                  zero,
  output logic                  pcEn,
  output logic                  iorD,
  output logic                  memWrite,
  output logic                  irWrite,
  output logic                  regDst,
  output logic                  memToReg,
  output logic                  regWrite,
  output logic                  aluSrcA,
  output logic [1:0]            aluSrcB,
  output logic [ALU_CTRL_W-1:0] aluControl,
  output logic [1:0]            pcSrc,
  output logic                  illegalOp,
  output logic [3:0]            state
);

  state_t                state_q, cur, nxt;
  logic [ALU_CTRL_W-1:0] fn_ctrl;
  logic                  fn_valid;
  logic                  pcWrite, branch, branchNe;
  logic                  ir_w, reg_w, mem_w, ill;

  alu_decoder #(.FUNCT_W(FUNCT_W), .ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .funct     (funct),
    .aluControl(fn_ctrl),
    .functValid(fn_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= nxt;
  end

  always_comb begin
    // During reset the decode shows FETCH; write enables are masked below.
    cur        = reset ? S_FETCH : state_q;
    nxt        = S_FETCH;
    pcWrite    = 1'b0;
    branch     = 1'b0;
    branchNe   = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    ill        = 1'b0;
    iorD       = 1'b0;
    regDst     = 1'b0;
    memToReg   = 1'b0;
    aluSrcA    = 1'b0;
    aluSrcB    = SRCB_B;
    aluControl = ALU_ADD;
    pcSrc      = PCSRC_ALU;
    case (cur)
      S_FETCH: begin
        ir_w    = 1'b1;
        aluSrcB = SRCB_FOUR;
        pcWrite = 1'b1;
        nxt     = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE: begin
            if (fn_valid) nxt = S_EXECUTE;
            else          ill = 1'b1;
          end
          OP_BEQ:  nxt = S_BRANCH;
          OP_ADDI: nxt = S_ADDIEX;
          OP_J:    nxt = S_JUMP;
`ifdef CTRL_BNE_EN
          OP_BNE:  nxt = S_BRANCHNE;
`endif
          default: ill = 1'b1;
        endcase
      end
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        nxt     = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        iorD = 1'b1;
        nxt  = S_MEMWB;
      end
      S_MEMWB: begin
        memToReg = 1'b1;
        reg_w    = 1'b1;
      end
      S_MEMWRITE: begin
        iorD  = 1'b1;
        mem_w = 1'b1;
      end
      S_EXECUTE: begin
        aluSrcA    = 1'b1;
        aluControl = fn_ctrl;
        nxt        = S_ALUWB;
      end
      S_ALUWB: begin
        regDst = 1'b1;
        reg_w  = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA    = 1'b1;
        aluControl = ALU_SUB;
        pcSrc      = PCSRC_ALUOUT;
        branch     = 1'b1;
      end
`ifdef CTRL_BNE_EN
      S_BRANCHNE: begin
        aluSrcA    = 1'b1;
        aluControl = ALU_SUB;
        pcSrc      = PCSRC_ALUOUT;
        branchNe   = 1'b1;
      end
`endif
      S_ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        nxt     = S_ADDIWB;
      end
      S_ADDIWB: reg_w = 1'b1;
      S_JUMP: begin
        pcSrc   = PCSRC_JUMP;
        pcWrite = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

  assign pcEn      = ~reset & (pcWrite | (branch & zero) | (branchNe & ~zero));
  assign irWrite   = ~reset & ir_w;
  assign regWrite  = ~reset & reg_w;
  assign memWrite  = ~reset & mem_w;
  assign illegalOp = ~reset & ill;
  assign state     = cur;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench: per-cycle vector table plus hand-written reset and latency sequences.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       pcEn, iorD, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA;
  logic [1:0] aluSrcB, pcSrc;
  logic [2:0] aluControl;
  logic       illegalOp;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pcEn(pcEn), .iorD(iorD), .memWrite(memWrite), .irWrite(irWrite),
    .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluControl(aluControl), .pcSrc(pcSrc),
    .illegalOp(illegalOp), .state(state)
  );

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [3:0]  st;
    logic [15:0] o;
  } vec_t;

  vec_t vq[$];

  // {pcEn,iorD,memWrite,irWrite,regDst,memToReg,regWrite,aluSrcA,aluSrcB,aluControl,pcSrc,illegalOp}
  function automatic logic [15:0] ow(input logic pe, input logic io, input logic mw,
                                     input logic iw, input logic rd, input logic m2r,
                                     input logic rw, input logic sa, input logic [1:0] sb,
                                     input logic [2:0] ac, input logic [1:0] ps,
                                     input logic il);
    return {pe, io, mw, iw, rd, m2r, rw, sa, sb, ac, ps, il};
  endfunction

  logic [15:0] O_FETCH, O_RST, O_DEC, O_ILL, O_MADR, O_MRD, O_MWB, O_MWR;
  logic [15:0] O_ALUWB, O_BR0, O_BR1, O_AEX, O_AWB, O_JMP;

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic [3:0] st, input logic [15:0] o);
    vec_t v;
    v.rst = r; v.op = op; v.fn = fn; v.z = z; v.st = st; v.o = o;
    vq.push_back(v);
  endtask

  function automatic logic [15:0] o_exec(input logic [2:0] ac);
    return ow(0,0,0,0,0,0,0,1,2'b00,ac,2'b00,0);
  endfunction

  function automatic logic [19:0] dut_word();
    return {state, pcEn, iorD, memWrite, irWrite, regDst, memToReg, regWrite,
            aluSrcA, aluSrcB, aluControl, pcSrc, illegalOp};
  endfunction

  task automatic check(input string name, input logic [19:0] exp);
    logic [19:0] got;
    got = dut_word();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got state/outs %h, required %h", name, got, exp);
    end
  endtask

  task automatic count_latency(input logic [5:0] op, input logic [5:0] fn, input int exp);
    int cyc;
    reset = 0; opcode = op; funct = fn; zero = 0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (state != 4'd0 && cyc < 20);
    n_tests++;
    if (cyc != exp) begin
      n_fail++;
      $display("FAIL latency op=%b: got %0d cycles, required %0d", op, cyc, exp);
    end
  endtask

  initial begin
    O_FETCH = ow(1,0,0,1,0,0,0,0,2'b01,3'b000,2'b00,0);
    O_RST   = ow(0,0,0,0,0,0,0,0,2'b01,3'b000,2'b00,0);
    O_DEC   = ow(0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,0);
    O_ILL   = ow(0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,1);
    O_MADR  = ow(0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0);
    O_MRD   = ow(0,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0);
    O_MWB   = ow(0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0);
    O_MWR   = ow(0,1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0);
    O_ALUWB = ow(0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0);
    O_BR0   = ow(0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01,0);
    O_BR1   = ow(1,0,0,0,0,0,0,1,2'b00,3'b001,2'b01,0);
    O_AEX   = ow(0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0);
    O_AWB   = ow(0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0);
    O_JMP   = ow(1,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0);

    add(1, 6'b100011, 0, 0, 0, O_RST);
    add(1, 6'b100011, 0, 1, 0, O_RST);
    // lw
    add(0, 6'b100011, 0, 0, 0, O_FETCH);
    add(0, 6'b100011, 0, 0, 1, O_DEC);
    add(0, 6'b100011, 0, 0, 2, O_MADR);
    add(0, 6'b100011, 0, 0, 3, O_MRD);
    add(0, 6'b100011, 0, 0, 4, O_MWB);
    // sw
    add(0, 6'b101011, 0, 0, 0, O_FETCH);
    add(0, 6'b101011, 0, 0, 1, O_DEC);
    add(0, 6'b101011, 0, 0, 2, O_MADR);
    add(0, 6'b101011, 0, 0, 5, O_MWR);
    // R-type slt, sub, or
    add(0, 6'b000000, 6'b101010, 0, 0, O_FETCH);
    add(0, 6'b000000, 6'b101010, 0, 1, O_DEC);
    add(0, 6'b000000, 6'b101010, 0, 6, o_exec(3'b100));
    add(0, 6'b000000, 6'b101010, 0, 7, O_ALUWB);
    add(0, 6'b000000, 6'b100010, 0, 0, O_FETCH);
    add(0, 6'b000000, 6'b100010, 0, 1, O_DEC);
    add(0, 6'b000000, 6'b100010, 0, 6, o_exec(3'b001));
    add(0, 6'b000000, 6'b100010, 0, 7, O_ALUWB);
    add(0, 6'b000000, 6'b100101, 0, 0, O_FETCH);
    add(0, 6'b000000, 6'b100101, 0, 1, O_DEC);
    add(0, 6'b000000, 6'b100101, 0, 6, o_exec(3'b011));
    add(0, 6'b000000, 6'b100101, 0, 7, O_ALUWB);
    // beq taken, zero also high in DECODE
    add(0, 6'b000100, 0, 1, 0, O_FETCH);
    add(0, 6'b000100, 0, 1, 1, O_DEC);
    add(0, 6'b000100, 0, 1, 8, O_BR1);
    // beq not taken
    add(0, 6'b000100, 0, 0, 0, O_FETCH);
    add(0, 6'b000100, 0, 0, 1, O_DEC);
    add(0, 6'b000100, 0, 0, 8, O_BR0);
    // addi, j
    add(0, 6'b001000, 0, 0, 0, O_FETCH);
    add(0, 6'b001000, 0, 0, 1, O_DEC);
    add(0, 6'b001000, 0, 1, 9, O_AEX);
    add(0, 6'b001000, 0, 1, 10, O_AWB);
    add(0, 6'b000010, 0, 1, 0, O_FETCH);
    add(0, 6'b000010, 0, 1, 1, O_DEC);
    add(0, 6'b000010, 0, 0, 11, O_JMP);
    // illegal opcode, then illegal funct
    add(0, 6'b111111, 0, 0, 0, O_FETCH);
    add(0, 6'b111111, 0, 0, 1, O_ILL);
    add(0, 6'b000000, 6'b000000, 0, 0, O_FETCH);
    add(0, 6'b000000, 6'b000000, 0, 1, O_ILL);
    // bne
    add(0, 6'b000101, 0, 0, 0, O_FETCH);
`ifdef CTRL_BNE_EN
    add(0, 6'b000101, 0, 0, 1, O_DEC);
    add(0, 6'b000101, 0, 0, 12, O_BR1);
    add(0, 6'b000101, 0, 1, 0, O_FETCH);
    add(0, 6'b000101, 0, 1, 1, O_DEC);
    add(0, 6'b000101, 0, 1, 12, O_BR0);
`else
    add(0, 6'b000101, 0, 0, 1, O_ILL);
`endif
    // reset in MEMREAD of an lw
    add(0, 6'b100011, 0, 0, 0, O_FETCH);
    add(0, 6'b100011, 0, 0, 1, O_DEC);
    add(0, 6'b100011, 0, 0, 2, O_MADR);
    add(1, 6'b100011, 0, 0, 0, O_RST);
    add(0, 6'b100011, 0, 0, 0, O_FETCH);
    add(0, 6'b100011, 0, 0, 1, O_DEC);

    reset = 1; opcode = 0; funct = 0; zero = 0;
    @(posedge clk); #1;
    foreach (vq[i]) begin
      reset = vq[i].rst; opcode = vq[i].op; funct = vq[i].fn; zero = vq[i].z;
      #1;
      check($sformatf("vec%0d", i), {vq[i].st, vq[i].o});
      @(posedge clk); #1;
    end

    // Hand sequence: reset held while the FSM sits in MEMREAD, checked after the edge.
    reset = 1; @(posedge clk); #1;
    reset = 0; opcode = 6'b100011; funct = 0; zero = 0;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_reset_memread", {4'd3, O_MRD});
    reset = 1; #1;
    check("reset_mask_memread", {4'd0, O_RST});
    @(posedge clk); #1;
    check("reset_state_after_edge", {4'd0, O_RST});
    reset = 0; #1;
    check("first_fetch_after_reset", {4'd0, O_FETCH});

    // Hand sequence: instruction latencies measured from FETCH.
    count_latency(6'b100011, 0, 5);
    count_latency(6'b101011, 0, 4);
    count_latency(6'b000000, 6'b100000, 4);
    count_latency(6'b001000, 0, 4);
    count_latency(6'b000100, 0, 3);
    count_latency(6'b000010, 0, 3);
    count_latency(6'b111111, 0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
